// File: rtl/window_accum_pkg.sv
// Shared types and constants for the window accumulator: FSM states,
// default window/accumulator sizes and the two sample-lane widths.
package window_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int unsigned WINDOW_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 24;
    localparam int unsigned S1_W       = 8;
    localparam int unsigned S2_W       = 16;

endpackage

// File: rtl/accum_sat_add.sv
// W-bit unsigned adder: clamps to all-ones on carry-out when WINDOW_ACCUM_SAT_EN
// is defined, otherwise wraps and reports no clamp.
module accum_sat_add #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

`ifdef WINDOW_ACCUM_SAT_EN
    logic [W:0] raw_s;

    assign raw_s = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o = raw_s[W];
    assign sum_o = raw_s[W] ? {W{1'b1}} : raw_s[W-1:0];
`else
    // ovf_o flags a clamp; the wrapping build never clamps.
    assign sum_o = a_i + b_i;
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/window_accum.sv
// Accumulates the product lane and tracks the sum-lane maximum over WINDOW
// accepted samples, then holds the result behind a valid/ready handshake.
// Optional clamping build: WINDOW_ACCUM_SAT_EN.
module window_accum
    import window_accum_pkg::*;
#(
    parameter int unsigned WINDOW = WINDOW_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [S1_W-1:0]  s1_in,
    input  logic [S2_W-1:0]  s2_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic [S1_W-1:0]  max_out,
    output logic             sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = $clog2(WINDOW + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_s;
    logic [ACC_W-1:0]   acc_q, acc_d, add_sum_s;
    logic [S1_W-1:0]    max_q, max_d, max_new_s;
    logic               satf_q, satf_d, add_ovf_s;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [S1_W-1:0]    maxo_q, maxo_d;
    logic               sat_q, sat_d;
    logic               ov_q, ov_d;

    // acc_q is zero in IDLE, so one adder serves the first and later samples.
    accum_sat_add #(.W(ACC_W)) u_add (
        .a_i   (acc_q),
        .b_i   (ACC_W'(s2_in)),
        .sum_o (add_sum_s),
        .ovf_o (add_ovf_s)
    );

    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign max_new_s = (s1_in > max_q) ? s1_in : max_q;
    assign in_ready  = (state_q != HOLD);

    // Next-state and datapath selection for the window FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        max_d   = max_q;
        satf_d  = satf_q;
        sum_d   = sum_q;
        maxo_d  = maxo_q;
        sat_d   = sat_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (in_valid) begin
                    cnt_d  = cnt_inc_s;
                    acc_d  = add_sum_s;
                    max_d  = max_new_s;
                    satf_d = satf_q | add_ovf_s;
                    if (cnt_inc_s == CNT_W'(WINDOW)) begin
                        state_d = HOLD;
                        sum_d   = add_sum_s;
                        maxo_d  = max_new_s;
                        sat_d   = satf_q | add_ovf_s;
                        ov_d    = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    max_d   = '0;
                    satf_d  = 1'b0;
                    ov_d    = 1'b0;
                end else begin
                    ov_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = '0;
                max_d   = '0;
                satf_d  = 1'b0;
                ov_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            max_q   <= '0;
            satf_q  <= 1'b0;
            sum_q   <= '0;
            maxo_q  <= '0;
            sat_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            satf_q  <= satf_d;
            sum_q   <= sum_d;
            maxo_q  <= maxo_d;
            sat_q   <= sat_d;
            ov_q    <= ov_d;
        end
    end

    assign sum_out   = sum_q;
    assign max_out   = maxo_q;
    assign sat       = sat_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_window_accum.sv
// Directed bench for window_accum with WINDOW=4, ACC_W=16; expected values
// are hand-computed, with the overflow case following WINDOW_ACCUM_SAT_EN.
module tb_window_accum;

    localparam int unsigned W  = 4;
    localparam int unsigned AW = 16;

    logic          clk;
    logic          reset;
    logic [7:0]    s1_in;
    logic [15:0]   s2_in;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] sum_out;
    logic [7:0]    max_out;
    logic          sat;
    logic          out_valid;
    logic          out_ready;

    int errors = 0;
    int checks = 0;

    window_accum #(.WINDOW(W), .ACC_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .s1_in     (s1_in),
        .s2_in     (s2_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_out   (sum_out),
        .max_out   (max_out),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        s1_in    = a;
        s2_in    = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        s1_in     = 8'd5;
        s2_in     = 16'd7;
        out_ready = 1'b1;

        // Reset held three cycles with input traffic present
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_sum", 32'(sum_out), 32'd0);
            check("rst_max", 32'(max_out), 32'd0);
            check("rst_sat", 32'(sat), 32'd0);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back window, result arrives in HOLD with out_ready low
        out_ready = 1'b0;
        send(8'd12, 16'd35);
        send(8'd17, 16'd35);
        send(8'd9,  16'd35);
        check("b2b_not_yet", 32'(out_valid), 32'd0);
        check("b2b_ready_mid", 32'(in_ready), 32'd1);
        send(8'd3,  16'd35);
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_sum", 32'(sum_out), 32'd140);
        check("b2b_max", 32'(max_out), 32'd17);
        check("b2b_sat", 32'(sat), 32'd0);

        // Backpressure: HOLD ignores new data while out_ready is low
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            s1_in    = 8'(200 + i);
            s2_in    = 16'(1000 * (i + 1));
            tick();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum_out), 32'd140);
            check("bp_max", 32'(max_out), 32'd17);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Gapped input: only valid cycles count
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(8'(10 * i), 16'(i));
            if (i < 4) begin
                check("gap_not_yet", 32'(out_valid), 32'd0);
            end
            s2_in = 16'd99;
            s1_in = 8'd250;
            tick();
        end
        check("gap_valid", 32'(out_valid), 32'd1);
        check("gap_sum", 32'(sum_out), 32'd10);
        check("gap_max", 32'(max_out), 32'd40);
        out_ready = 1'b1;
        tick();
        check("gap_release", 32'(out_valid), 32'd0);

        // Minimum inter-window gap; the sample offered during HOLD is dropped
        send(8'd200, 16'd10);
        send(8'd255, 16'd20);
        send(8'd0,   16'd30);
        send(8'd1,   16'd40);
        check("min_valid", 32'(out_valid), 32'd1);
        check("min_sum", 32'(sum_out), 32'd100);
        check("min_max", 32'(max_out), 32'd255);
        send(8'd77, 16'd1000);
        check("min_hold_exit", 32'(out_valid), 32'd0);
        check("min_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send(8'd0, 16'd2);
        end
        check("next_sum", 32'(sum_out), 32'd8);
        check("next_max", 32'(max_out), 32'd0);
        tick();

        // Overflow of the 16-bit accumulator
        for (int i = 0; i < 4; i++) begin
            send(8'd1, 16'hFFFF);
        end
        check("ovf_valid", 32'(out_valid), 32'd1);
`ifdef WINDOW_ACCUM_SAT_EN
        check("ovf_sum", 32'(sum_out), 32'h0000_FFFF);
        check("ovf_sat", 32'(sat), 32'd1);
`else
        check("ovf_sum", 32'(sum_out), 32'h0000_FFFC);
        check("ovf_sat", 32'(sat), 32'd0);
`endif
        tick();

        // Mid-window reset discards the partial sum
        send(8'd50, 16'd100);
        send(8'd50, 16'd100);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum_out), 32'd0);
        check("mid_rst_sat", 32'(sat), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'd3, 16'd5);
        end
        check("mid_valid", 32'(out_valid), 32'd1);
        check("mid_sum", 32'(sum_out), 32'd20);
        check("mid_max", 32'(max_out), 32'd3);

        // Reset in HOLD wins over a simultaneous out_ready
        out_ready = 1'b1;
        reset     = 1'b0;
        tick();
        reset     = 1'b1;
        out_ready = 1'b0;
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_sum", 32'(sum_out), 32'd0);
        check("hold_rst_max", 32'(max_out), 32'd0);
        check("hold_rst_ready", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_accum.md
# window_accum

Downstream consumer of the arithmetic pipeline's two result streams: the 8-bit sum lane (s1) and the 16-bit product lane (s2). It accumulates the product lane over a fixed window of accepted samples and tracks the maximum of the sum lane over the same window. It then presents the window total and maximum behind a valid/ready output handshake. It throttles the upstream stage through in_ready while a result is waiting to be taken.

## Interface
- WINDOW, 8, number of accepted samples per result; legal range 1..256
- ACC_W, 24, accumulator and sum_out width; legal range 16..32
- clk  in  1  clock, rising-edge
- reset  in  1  reset, synchronous, active-low
- s1_in  in  8  sum-lane sample
- s2_in  in  16  product-lane sample
- in_valid  in  1  s1_in/s2_in carry a sample this cycle
- in_ready  out  1  block accepts a sample this cycle
- sum_out  out  ACC_W  window total of s2_in
- max_out  out  8  window maximum of s1_in (unsigned)
- sat  out  1  window total clamped (see Configuration)
- out_valid  out  1  sum_out/max_out/sat hold a completed window
- out_ready  in  1  downstream takes the result

## Operation
- Accept = in_valid && in_ready at a rising clk edge.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD; combinational from the state register only.
- State IDLE: count=0, acc=0, max=0.
  - On accept: acc=s2_in (zero-extended), max=s1_in, count=1.
  - Go to HOLD if WINDOW==1, else to ACCUM.
- State ACCUM:
  - On accept: acc=acc+s2_in, max=max(max,s1_in), count=count+1.
  - When count reaches WINDOW, go to HOLD. The sum_out/max_out/sat registers load on that same edge.
  - No accept: all state unchanged.
- State HOLD:
  - out_valid=1; outputs frozen; in_valid ignored.
  - On out_valid && out_ready: go to IDLE, clear count/acc/max, out_valid=0.
- Unsigned arithmetic throughout; s2_in is zero-extended to ACC_W before adding.
- count is $clog2(WINDOW+1) bits wide.
- Reset at any time, including mid-window or in HOLD:
  - State goes to IDLE and partial accumulation is discarded.
  - sum_out=0, max_out=0, sat=0, out_valid=0.
  - in_ready=1 from the first cycle after reset deasserts.

## Timing
- Result latency: out_valid rises on the edge that accepts the WINDOW-th sample. It is visible in the cycle after that edge.
- Back-to-back samples sustain 1 sample/cycle within a window.
- Minimum gap between windows: 1 cycle (the HOLD cycle), when out_ready=1 on arrival in HOLD.
- The first sample of the next window can be accepted in the cycle after the output handshake.
- out_valid never drops without out_ready; sum_out/max_out/sat are stable while out_valid=1.
- Simultaneous reset low and out_ready: reset wins.

## Configuration
- Macro WINDOW_ACCUM_SAT_EN.
- Defined: each addition clamps to 2^ACC_W-1 on overflow. sat is set for the window if any clamp occurred.
- Undefined: the accumulator wraps modulo 2^ACC_W and sat is tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package window_accum_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD)
  - default WINDOW and ACC_W constants
  - sample-lane width constants: 8 for the sum lane, 16 for the product lane
- One sub-module, accum_sat_add: an ACC_W-bit add that is saturating or wrapping under the macro, with an overflow output.
- FSM, counter and max tracking stay in the top module.

## Test plan
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, sum_out=0, max_out=0, sat=0; in_ready=1 in the first cycle after release.
- WINDOW=4: back-to-back s2_in=35 with s1_in=12,17,9,3 -> out_valid=1 one cycle after the 4th accept, sum_out=140, max_out=17, sat=0.
- Backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 and changing data -> in_ready=0, outputs unchanged; then out_ready=1 -> next cycle out_valid=0, in_ready=1.
- Gapped input: WINDOW=4, in_valid on alternate cycles with s2_in=1,2,3,4 -> sum_out=10; only valid cycles counted.
- Overflow, ACC_W=16: four samples of s2_in=0xFFFF -> without macro sum_out=0xFFFC, sat=0; with WINDOW_ACCUM_SAT_EN, sum_out=0xFFFF, sat=1.
- Mid-window reset: WINDOW=4, 2 samples of 100, pulse reset=0 one cycle, then 4 samples of 5 -> sum_out=20; no stale contribution.
